// File: rtl/seq_cla_adder.sv
// Multi-cycle carry-lookahead adder: one GROUP-bit chunk per cycle, LSB chunk first,
// folding chunk generate/propagate into word-level G/P behind valid/ready handshakes.
module seq_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             g_out,
  output logic             p_out
);

  localparam int NCHUNK = WIDTH / GROUP;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Lookahead over one chunk: every carry is formed from the prefix generate/propagate
  // of the bits below it and the chunk carry-in. Result is {Gk, Pk, cout, s}.
  function automatic logic [GROUP+2:0] cla_chunk(
    input logic [GROUP-1:0] ca,
    input logic [GROUP-1:0] cb,
    input logic             cin
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] s;
    logic [GROUP:0]   c;
    logic             gg;
    logic             pp;
    g    = ca & cb;
    p    = ca ^ cb;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      gg     = g[i] | (p[i] & gg);
      pp     = p[i] & pp;
      c[i+1] = gg | (pp & cin);
    end
    s = p ^ c[GROUP-1:0];
    return {gg, pp, c[GROUP], s};
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic               gacc_q, gacc_d;
  logic               pacc_q, pacc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               g_out_q, g_out_d;
  logic               p_out_q, p_out_d;
  logic               out_valid_q, out_valid_d;

  logic [GROUP-1:0]   a_chunk;
  logic [GROUP-1:0]   b_chunk;
  logic [GROUP+2:0]   chunk_res;
  logic [GROUP-1:0]   chunk_s;
  logic               chunk_c;
  logic               chunk_g;
  logic               chunk_p;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_chunk = a_q[k*GROUP +: GROUP];
        b_chunk = b_q[k*GROUP +: GROUP];
      end
    end
    chunk_res = cla_chunk(a_chunk, b_chunk, carry_q);
    chunk_s   = chunk_res[GROUP-1:0];
    chunk_c   = chunk_res[GROUP];
    chunk_p   = chunk_res[GROUP+1];
    chunk_g   = chunk_res[GROUP+2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    gacc_d      = gacc_q;
    pacc_d      = pacc_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    g_out_d     = g_out_q;
    p_out_d     = p_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          gacc_d  = 1'b0;
          pacc_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*GROUP +: GROUP] = chunk_s;
        end
        carry_d = chunk_c;
        gacc_d  = chunk_g | (chunk_p & gacc_q);
        pacc_d  = chunk_p & pacc_q;
        if (cnt_q == LAST_CHUNK) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          c_out_d     = chunk_c;
          g_out_d     = gacc_d;
          p_out_d     = pacc_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      gacc_q      <= 1'b0;
      pacc_q      <= 1'b1;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      g_out_q     <= 1'b0;
      p_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      gacc_q      <= gacc_d;
      pacc_q      <= pacc_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      g_out_q     <= g_out_d;
      p_out_q     <= p_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand registers are pure data: only ever read in RUN, after a load in IDLE.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign g_out     = g_out_q;
  assign p_out     = p_out_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed + randomized bench for seq_cla_adder (WIDTH=16, GROUP=4) with an arithmetic reference model.
module tb_seq_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        g_out;
  logic        p_out;

  int checks = 0;
  int errors = 0;

  seq_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .g_out(g_out), .p_out(p_out)
  );

  always #5 clk = ~clk;

  // Reference: {c_out, g_out, p_out, sum} from plain integer addition.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
    logic [16:0] t;
    logic [16:0] t0;
    t  = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
    t0 = {1'b0, ma} + {1'b0, mb};
    return {t[16], t0[16], &(ma ^ mb), t[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [18:0] e, input logic cin);
    chk({tag, "_sum"}, 32'(sum), 32'(e[15:0]));
    chk({tag, "_cout"}, 32'(c_out), 32'(e[18]));
    chk({tag, "_gout"}, 32'(g_out), 32'(e[17]));
    chk({tag, "_pout"}, 32'(p_out), 32'(e[16]));
    chk({tag, "_inv"}, 32'(c_out), 32'(g_out | (p_out & cin)));
  endtask

  // Present operands, accept, scramble inputs, wait (bounded) for out_valid, check.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input string tag);
    logic [18:0] e;
    int lat;
    e = model(ta, tb, tc);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    check_result(tag, e, tc);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [18:0] e;
    logic [15:0] held_sum;
    logic        held_cout;
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic        pc [3];
    logic [18:0] expq [$];
    logic        cq [$];
    logic        acc;
    int          cyc, nacc, nres, last, seen;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {29'd0, c_out, g_out, p_out}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run_op(16'hFFFF, 16'h0001, 1'b0, "ffff_p1");
    release_result("ffff_p1");
    run_op(16'h1234, 16'h4321, 1'b1, "mixed");
    release_result("mixed");
    run_op(16'hAAAA, 16'h5555, 1'b1, "ripple_c1");
    release_result("ripple_c1");
    run_op(16'hAAAA, 16'h5555, 1'b0, "ripple_c0");

    // Backpressure: result holds while new operands are offered.
    held_sum = sum; held_cout = c_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(held_sum));
      chk("bp_cout", 32'(c_out), 32'(held_cout));
    end
    in_valid = 1'b0;
    release_result("bp");

    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), "rand");
      release_result("rand");
    end

    // Reset mid-operation abandons the result.
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_rdy_low", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_rdy_high", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, "after_rst");
    release_result("after_rst");

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom); pc[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    a = pa[0]; b = pb[0]; c_in = pc[0]; in_valid = 1'b1;
    cyc = 0; nacc = 0; nres = 0; last = -1;
    while (nres < 3 && cyc < 60) begin
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        expq.push_back(model(a, b, c_in));
        cq.push_back(c_in);
        nacc++;
        if (nacc < 3) begin
          a = pa[nacc]; b = pb[nacc]; c_in = pc[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check_result("b2b", e, cq.pop_front());
        end else begin
          chk("b2b_unexpected", 32'(out_valid), 32'd0);
        end
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        nres++;
      end
    end
    chk("b2b_count", 32'(nres), 32'd3);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
